// File: rtl/mul_div.sv
`default_nettype none
// ============================================================================
// Module   : mul_div
// Brief    : Iterative RV32M multiply/divide unit, 32-bit radix-2 datapath.
// Revision : 1.0
// ============================================================================
module mul_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out,
    output logic        we_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_cnt;
    logic        r_post;
    logic [2:0]  r_op;
    logic [4:0]  r_rd;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_opnd;
    logic        r_neg;
    logic [31:0] r_result;
    logic [4:0]  r_rd_out;

    logic        w_sgn_a;
    logic        w_sgn_b;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_neg;
    logic [32:0] w_sum;
    logic [32:0] w_rem_sh;
    logic        w_geq;
    logic [31:0] w_diff;
    logic [63:0] w_prod;
    logic [63:0] w_prod_fix;
    logic [31:0] w_final;

    // Signedness per op: MULH/DIV/REM both signed, MULHSU only rs1 signed
    assign w_sgn_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_sgn_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_a_neg = w_sgn_a & op_a[31];
    assign w_b_neg = w_sgn_b & op_b[31];
    assign w_mag_a = w_a_neg ? (~op_a + 32'd1) : op_a;
    assign w_mag_b = w_b_neg ? (~op_b + 32'd1) : op_b;
    // Remainder follows the dividend; a zero divisor never negates the quotient
    assign w_neg   = funct3[2] ? (funct3[1] ? w_a_neg : ((w_a_neg ^ w_b_neg) & (op_b != 32'd0)))
                               : (w_a_neg ^ w_b_neg);

    // Multiply: {hi,lo} shifts right, lo starts as the multiplier
    assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : 33'd0);
    // Divide: {hi,lo} shifts left, lo starts as the dividend and collects quotient bits
    assign w_rem_sh = {r_hi, r_lo[31]};
    assign w_geq    = (w_rem_sh >= {1'b0, r_opnd});
    assign w_diff   = w_rem_sh[31:0] - r_opnd;

    assign w_prod     = {r_hi, r_lo};
    assign w_prod_fix = r_neg ? (~w_prod + 64'd1) : w_prod;

    always_comb begin
        w_final = 32'd0;
        if (r_op[2]) begin
            if (r_op[1]) w_final = r_neg ? (~r_hi + 32'd1) : r_hi;
            else         w_final = r_neg ? (~r_lo + 32'd1) : r_lo;
        end else if (r_op[1:0] == 2'b00) begin
            w_final = w_prod_fix[31:0];
        end else begin
            w_final = w_prod_fix[63:32];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CALC;
            S_CALC:  if (r_post) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_post   <= 1'b0;
            r_op     <= 3'd0;
            r_rd     <= 5'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_opnd   <= 32'd0;
            r_neg    <= 1'b0;
            r_result <= 32'd0;
            r_rd_out <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op   <= funct3;
                        r_rd   <= rd_in;
                        r_neg  <= w_neg;
                        r_hi   <= 32'd0;
                        r_lo   <= funct3[2] ? w_mag_a : w_mag_b;
                        r_opnd <= funct3[2] ? w_mag_b : w_mag_a;
                        r_cnt  <= 5'd0;
                        r_post <= 1'b0;
                    end
                end
                S_CALC: begin
                    if (!r_post) begin
                        if (r_op[2]) begin
                            r_hi <= w_geq ? w_diff : w_rem_sh[31:0];
                            r_lo <= {r_lo[30:0], w_geq};
                        end else begin
                            {r_hi, r_lo} <= {w_sum, r_lo[31:1]};
                        end
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) r_post <= 1'b1;
                    end else begin
                        // Extra CALC cycle applies the sign fix and loads the outputs on FIN entry
                        r_result <= w_final;
                        r_rd_out <= r_rd;
                        r_post   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_FIN);
    assign result = r_result;
    assign rd_out = r_rd_out;
    assign we_out = done & (r_rd_out != 5'd0);

endmodule
`default_nettype wire

// File: tb/tb_mul_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div
// Brief    : Directed vector bench for mul_div with hand-computed results.
// Revision : 1.0
// ============================================================================
module tb_mul_div;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        we_out;

    int checks   = 0;
    int failures = 0;

    mul_div u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out),
        .we_out (we_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at a negedge one cycle after done
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int stray_at);
        int k;
        funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; funct3 = ~f; op_a = ~a; op_b = b + 32'd1; rd_in = ~rd;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        k = 1;
        while (k <= 40) begin
            if (k == stray_at) begin
                start = 1'b1; funct3 = 3'b000; op_a = 32'd1000; op_b = 32'd1000; rd_in = 5'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (done) break;
            k++;
        end
        start = 1'b0;
        check("latency", k, 32'd33);
        check("result", result, exp);
        check("rd_out", {27'd0, rd_out}, {27'd0, rd});
        check("we_out", {31'd0, we_out}, {31'd0, (rd != 5'd0)});
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("idle_after_fin", {31'd0, busy}, 32'd0);
        check("result_hold", result, exp);
    endtask

    initial begin
        int ndone;

        vecs[0]  = '{3'b000, 32'd7,          32'd6,          5'd5,  32'd42};
        vecs[1]  = '{3'b001, 32'h80000000,   32'h80000000,   5'd1,  32'h40000000};
        vecs[2]  = '{3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF,   5'd2,  32'hFFFFFFFE};
        vecs[3]  = '{3'b100, 32'hFFFFFFF9,   32'd2,          5'd3,  32'hFFFFFFFD};
        vecs[4]  = '{3'b110, 32'hFFFFFFF9,   32'd2,          5'd4,  32'hFFFFFFFF};
        vecs[5]  = '{3'b101, 32'd100,        32'd0,          5'd6,  32'hFFFFFFFF};
        vecs[6]  = '{3'b111, 32'd100,        32'd0,          5'd7,  32'd100};
        vecs[7]  = '{3'b100, 32'h80000000,   32'hFFFFFFFF,   5'd8,  32'h80000000};
        vecs[8]  = '{3'b110, 32'h80000000,   32'hFFFFFFFF,   5'd9,  32'd0};
        vecs[9]  = '{3'b010, 32'hFFFFFFFF,   32'd2,          5'd10, 32'hFFFFFFFF};
        vecs[10] = '{3'b010, 32'h80000000,   32'hFFFFFFFF,   5'd11, 32'h80000000};
        vecs[11] = '{3'b000, 32'hFFFFFFFD,   32'd5,          5'd12, 32'hFFFFFFF1};
        vecs[12] = '{3'b001, 32'hFFFFFFFD,   32'd5,          5'd13, 32'hFFFFFFFF};
        vecs[13] = '{3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF,   5'd14, 32'd0};
        vecs[14] = '{3'b011, 32'h80000000,   32'd2,          5'd15, 32'd1};
        vecs[15] = '{3'b100, 32'd5,          32'd0,          5'd16, 32'hFFFFFFFF};
        vecs[16] = '{3'b110, 32'hFFFFFFFB,   32'd0,          5'd17, 32'hFFFFFFFB};
        vecs[17] = '{3'b101, 32'hFFFFFFFF,   32'd3,          5'd18, 32'h55555555};
        vecs[18] = '{3'b111, 32'd100,        32'd7,          5'd19, 32'd2};
        vecs[19] = '{3'b100, 32'd100,        32'hFFFFFFF9,   5'd20, 32'hFFFFFFF2};
        vecs[20] = '{3'b110, 32'd100,        32'hFFFFFFF9,   5'd21, 32'd2};
        vecs[21] = '{3'b000, 32'd3,          32'd3,          5'd0,  32'd9};

        rst_n = 1'b0; start = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy",   {31'd0, busy},   32'd0);
        check("reset_done",   {31'd0, done},   32'd0);
        check("reset_we",     {31'd0, we_out}, 32'd0);
        check("reset_result", result,          32'd0);
        check("reset_rd_out", {27'd0, rd_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++)
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, 0);

        // Stray start 10 cycles into an op must be dropped, not queued
        run_op(3'b000, 32'd11, 32'd13, 5'd22, 32'd143, 10);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("stray_start_ignored", ndone, 32'd0);

        // Start held high: FIN cycle ignores it, IDLE cycle accepts the new operands
        funct3 = 3'b000; op_a = 32'd2; op_b = 32'd3; rd_in = 5'd1; start = 1'b1;
        ndone = 0;
        while (!done && ndone < 40) begin
            @(negedge clk);
            ndone++;
        end
        check("b2b_first_latency", ndone, 32'd34);
        check("b2b_first_result", result, 32'd6);
        op_b = 32'd4;
        @(negedge clk);
        check("b2b_fin_start_ignored", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("b2b_idle_accept", {31'd0, busy}, 32'd1);
        start = 1'b0;
        ndone = 0;
        while (!done && ndone < 40) begin
            @(negedge clk);
            ndone++;
        end
        check("b2b_second_latency", ndone, 32'd33);
        check("b2b_second_result", result, 32'd8);
        @(negedge clk);

        // Reset in the middle of CALC aborts silently
        funct3 = 3'b000; op_a = 32'd7; op_b = 32'd7; rd_in = 5'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy",   {31'd0, busy},   32'd0);
        check("abort_done",   {31'd0, done},   32'd0);
        check("abort_we",     {31'd0, we_out}, 32'd0);
        check("abort_result", result,          32'd0);
        check("abort_rd_out", {27'd0, rd_out}, 32'd0);
        rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || we_out) ndone++;
        end
        check("abort_no_done", ndone, 32'd0);
        run_op(3'b000, 32'd3, 32'd3, 5'd0, 32'd9, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_div.md
MUL_DIV -- requirements
Module: mul_div

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 op_a  input  32  operand rs1, driven from register-file read port 1.
REQ-007 op_b  input  32  operand rs2, driven from register-file read port 2.
REQ-008 rd_in  input  5  destination register index.
REQ-009 busy  output  1  high while an operation is in flight.
REQ-010 done  output  1  one-cycle pulse marking result valid.
REQ-011 result  output  32  write-back data to the register-file write-data port.
REQ-012 rd_out  output  5  write-back index to the register-file write-address port.
REQ-013 we_out  output  1  write enable to the register-file write-enable port.

Function
REQ-014 States SHALL be IDLE, CALC and FIN.
- IDLE -> CALC: on start=1.
- CALC -> FIN: after exactly 32 iterations, counted by a 5-bit counter.
- FIN -> IDLE: unconditionally.
REQ-015 On accept, funct3, rd_in and the operands SHALL be latched; input changes afterwards SHALL NOT affect the operation.
REQ-016 Signed operands SHALL be converted to magnitudes at accept; MULHSU treats op_a as signed and op_b as unsigned.
REQ-017 Multiply SHALL be shift-add, one bit per CALC cycle, into a 64-bit product.
REQ-018 Multiply result: MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
REQ-019 Divide SHALL be restoring, one quotient bit per CALC cycle.
REQ-020 Sign fix SHALL occur in FIN: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
REQ-021 Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return op_a.
REQ-022 Signed overflow (0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
REQ-023 Latency SHALL be fixed for all ops and operands, including the special cases: start sampled at edge N, busy=1 from N+1, done=1 during the cycle following edge N+33.
REQ-024 busy SHALL be high in CALC and FIN, and low in IDLE.
REQ-025 done SHALL be high only in FIN, for exactly one cycle.
REQ-026 result and rd_out SHALL update at FIN entry and hold until the next FIN.
REQ-027 we_out SHALL equal done AND (rd_out != 0); x0 is never written.
REQ-028 start while busy=1 SHALL be ignored, with no queueing.
REQ-029 start asserted in the FIN cycle SHALL be ignored; a new op is accepted no earlier than the first IDLE cycle.
REQ-030 start held high continuously SHALL launch back-to-back ops, one accept per IDLE cycle.

Reset
REQ-031 With rst_n=0 at an edge, the block SHALL go to IDLE, clear the counter, and drive busy=0, done=0, we_out=0, result=0, rd_out=0.
REQ-032 Reset asserted mid-CALC or mid-FIN SHALL abort the operation with no done or we_out pulse; the next start after reset release SHALL behave normally.

Verification
REQ-033 MUL 7 x 6, rd_in=5 -> done 33 cycles after start with result=42, rd_out=5, we_out=1.
REQ-034 MULH 0x80000000 x 0x80000000 -> result 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE.
REQ-035 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100; all at the same latency.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000; REM of the same operands -> result 0.
REQ-037 Second start 10 cycles into an op, with different operands -> ignored; exactly one done pulse carrying the first op's result.
REQ-038 rst_n=0 at CALC cycle 15 -> no done pulse; all outputs 0. Then rd_in=0 MUL 3 x 3 -> result 9, done=1, we_out=0.
